// File: rtl/demux_1to4_pkg.sv
// Shared configuration for the registered demultiplexer slice: default widths
// and the lane-count helper used by both the top and the decoder.
package demux_1to4_pkg;

    // Default configuration: one data bit steered onto four lanes.
    localparam int DEFAULT_DATA_W = 1;
    localparam int DEFAULT_SEL_W  = 2;

    // Number of lanes addressed by a binary select of the given width.
    function automatic int lane_count(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/demux_1to4_decoder.sv
// Binary-to-one-hot decoder: drives exactly one of N_OUT bits high,
// the bit whose index equals the select value.
module demux_decoder
    import demux_1to4_pkg::*;
#(
    parameter int SEL_W = DEFAULT_SEL_W
) (
    input  logic [SEL_W-1:0]             sel,
    output logic [lane_count(SEL_W)-1:0] onehot
);

    localparam int N_OUT = lane_count(SEL_W);

    // Compare the full-width select against every lane index.
    always_comb begin
        onehot = '0;
        for (int k = 0; k < N_OUT; k++) begin
            onehot[k] = (sel == SEL_W'(k));
        end
    end

endmodule

// File: rtl/demux_1to4.sv
// Registered 1-to-N demultiplexer. The selected lane carries the input one
// cycle later and every other lane is held at zero. Only the output
// registers hold state, so there is no combinational input-to-output path.
module demux_1to4
    import demux_1to4_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int SEL_W  = DEFAULT_SEL_W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DATA_W-1:0]                   demux_in,
    input  logic [SEL_W-1:0]                    demux_signal,
    output logic [lane_count(SEL_W)*DATA_W-1:0] demux_out
);

    localparam int N_OUT = lane_count(SEL_W);

    logic [N_OUT-1:0]        lane_hot;
    logic [N_OUT*DATA_W-1:0] lane_next;

    demux_decoder #(
        .SEL_W (SEL_W)
    ) u_decoder (
        .sel    (demux_signal),
        .onehot (lane_hot)
    );

    // Gate the input onto each lane with that lane's one-hot bit.
    always_comb begin
        lane_next = '0;
        for (int k = 0; k < N_OUT; k++) begin
            lane_next[k*DATA_W +: DATA_W] = demux_in & {DATA_W{lane_hot[k]}};
        end
    end

    // Output registers: cleared asynchronously, loaded on every rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            demux_out <= '0;
        end else begin
            demux_out <= lane_next;
        end
    end

endmodule

// File: tb/tb_demux_1to4.sv
// Self-checking bench for demux_1to4: the default 1-bit/4-lane instance and
// an 8-bit/8-lane instance share the clock and reset. Directed cases are
// followed by randomized traffic checked against an arithmetic placement model.
module tb_demux_1to4;

    logic        clk;
    logic        rst_n;
    logic [0:0]  in_n;
    logic [1:0]  sel_n;
    logic [3:0]  out_n;
    logic [7:0]  in_w;
    logic [2:0]  sel_w;
    logic [63:0] out_w;

    int compared;
    int mismatched;

    logic [3:0]  exp_n;
    logic [63:0] exp_w;

    demux_1to4 dut_narrow (
        .clk          (clk),
        .rst_n        (rst_n),
        .demux_in     (in_n),
        .demux_signal (sel_n),
        .demux_out    (out_n)
    );

    demux_1to4 #(
        .DATA_W (8),
        .SEL_W  (3)
    ) dut_wide (
        .clk          (clk),
        .rst_n        (rst_n),
        .demux_in     (in_w),
        .demux_signal (sel_w),
        .demux_out    (out_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: the input value placed at bit offset sel*width, zeros elsewhere.
    task automatic applyStimulus(input logic [0:0] a_in, input logic [1:0] a_sel,
                                 input logic [7:0] b_in, input logic [2:0] b_sel);
        in_n  = a_in;
        sel_n = a_sel;
        in_w  = b_in;
        sel_w = b_sel;
        exp_n = 4'(a_in) << a_sel;
        exp_w = 64'(b_in) << (int'(b_sel) * 8);
    endtask

    task automatic edgeAndCheck(input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, "_n"}, 64'(out_n), 64'(exp_n));
        checkOutput({tag, "_w"}, out_w, exp_w);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b1;
        applyStimulus(1'b1, 2'd3, 8'hFF, 3'd7);

        // Reset clears outputs without any clock edge (first posedge at t=5).
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_async_n", 64'(out_n), 64'h0);
        checkOutput("reset_async_w", out_w, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_held_n", 64'(out_n), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 2'd0, 8'h11, 3'd0);
        edgeAndCheck("sel0");
        applyStimulus(1'b1, 2'd1, 8'h22, 3'd1);
        edgeAndCheck("sel1");
        checkOutput("sel1_const", 64'(out_n), 64'h2);
        applyStimulus(1'b1, 2'd2, 8'h33, 3'd2);
        edgeAndCheck("sel2");
        checkOutput("sel2_const", 64'(out_n), 64'h4);
        applyStimulus(1'b1, 2'd3, 8'h44, 3'd3);
        edgeAndCheck("sel3");
        checkOutput("sel3_const", 64'(out_n), 64'h8);

        applyStimulus(1'b0, 2'd3, 8'h00, 3'd5);
        edgeAndCheck("zero_in");
        applyStimulus(1'b1, 2'd3, 8'h80, 3'd7);
        edgeAndCheck("sel3_again");

        // Reset between edges while lane 3 is high.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_n", 64'(out_n), 64'h0);
        checkOutput("midreset_w", out_w, 64'h0);
        applyStimulus(1'b1, 2'd2, 8'h5A, 3'd4);
        #1 rst_n = 1'b1;
        edgeAndCheck("after_release");
        checkOutput("after_release_const", 64'(out_n), 64'h4);

        // Wide configuration directed case.
        applyStimulus(1'b0, 2'd0, 8'hA5, 3'd6);
        edgeAndCheck("wide_lane6");
        checkOutput("wide_lane6_const", out_w, 64'h00A5_0000_0000_0000);

        // Randomized traffic with occasional asynchronous resets between edges.
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'($urandom), 2'($urandom), 8'($urandom), 3'($urandom));
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                #1;
                checkOutput("rand_reset_n", 64'(out_n), 64'h0);
                checkOutput("rand_reset_w", out_w, 64'h0);
                rst_n = 1'b1;
            end
            edgeAndCheck("rand");
            checkOutput("rand_onehot0", 64'($onehot0(out_n)), 64'h1);
            checkOutput("rand_lane", 64'(out_n[sel_n]), 64'(in_n));
            checkOutput("rand_wide_lane", 64'(out_w[int'(sel_w)*8 +: 8]), 64'(in_w));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
